// File: rtl/runner_pkg.sv
// runner_pkg: shared game states, key codes, screen size and level-to-floor mapping for the runner.
package runner_pkg;
    typedef enum logic [1:0] {FILL, IDLE, PLAYING, DEAD} game_state_t;
    localparam logic [7:0] KEY_SPACE = 8'h2c;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;
    function automatic logic [9:0] level_floor(input logic [2:0] lvl);
        return (lvl == 3'd0) ? 10'(SCREEN_H) : 10'd416 - {3'd0, lvl, 4'd0};
    endfunction
endpackage

// File: rtl/ground_gen_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR (taps 16,14,13,11) that advances only when stepped.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        step,
    output logic [15:0] value
);
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) value <= SEED;
        else if (step) value <= {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
endmodule

// File: rtl/ground_gen.sv
// ground_gen: scrolling 16-slot terrain ring and game-state FSM for the runner.
// Define GROUND_SPEEDUP_EN to raise the scroll step by one every 16 points, up to 8.
module ground_gen
    import runner_pkg::*;
#(
    parameter int          SEG_W       = 64,
    parameter int          SCROLL_STEP = 4,
    parameter int          STICK_X     = 100,
    parameter int          STICK_W     = 56,
    parameter int          FALL_Y      = 470,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [7:0]  keycode,
    input  logic [9:0]  StickmanBottom,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    output logic [9:0]  GroundY,
    output logic        playing,
    output logic [15:0] Score,
    output logic        is_ground
);
    localparam int SH = $clog2(SEG_W);
    game_state_t r_state;
    logic [2:0]  r_lvl [16];
    logic [3:0]  r_head, r_cnt;
    logic [SH-1:0] r_off;
    logic [15:0] r_score;
    logic [9:0]  r_gy;
    logic [1:0]  r_fc;
    logic        r_playing, r_upd, r_prev_gap;
    logic [15:0] w_lfsr;
    logic [3:0]  w_step, w_slot_d, w_slot_a, w_slot_b;
    logic [SH:0] w_sum;
    logic [9:0]  w_floor_a, w_floor_b, w_gy_min;
    logic [2:0]  w_new;
    logic        w_tick, w_dead, w_adv, w_wrap, w_unused_lfsr;
    function automatic logic [3:0] slot_of(input logic [9:0] x, input logic [3:0] head, input logic [SH-1:0] off);
        logic [10:0] s;
        s = {1'b0, x} + 11'(off);
        return head + 4'(s >> SH);
    endfunction
    assign w_tick    = r_fc[0] & ~r_fc[1];
    assign w_dead    = (StickmanBottom > r_gy) || (StickmanBottom >= 10'(FALL_Y));
    assign w_sum     = {1'b0, r_off} + (SH+1)'(w_step);
    assign w_adv     = (r_state == PLAYING) && w_tick && !w_dead;
    assign w_wrap    = w_adv && w_sum[SH];
    assign w_new     = (w_lfsr[2:0] == 3'd0 && r_prev_gap) ? 3'd1 : w_lfsr[2:0];
    assign w_slot_d  = slot_of(DrawX, r_head, r_off);
    assign w_slot_a  = slot_of(10'(STICK_X), r_head, r_off);
    assign w_slot_b  = slot_of(10'(STICK_X + STICK_W - 1), r_head, r_off);
    assign w_floor_a = level_floor(r_lvl[w_slot_a]);
    assign w_floor_b = level_floor(r_lvl[w_slot_b]);
    assign w_gy_min  = (w_floor_a < w_floor_b) ? w_floor_a : w_floor_b;
    assign is_ground = (r_lvl[w_slot_d] != 3'd0) && (DrawY >= level_floor(r_lvl[w_slot_d]));
    assign w_unused_lfsr = ^w_lfsr[15:3];
    assign GroundY   = r_gy;
    assign playing   = r_playing;
    assign Score     = r_score;
    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .Clk   (Clk),
        .Reset (Reset),
        .step  (w_wrap),
        .value (w_lfsr)
    );
`ifdef GROUND_SPEEDUP_EN
    logic [3:0] r_step;
    always_ff @(posedge Clk or posedge Reset)
        if (Reset) r_step <= 4'(SCROLL_STEP);
        else if (r_state == FILL) r_step <= 4'(SCROLL_STEP);
        else if (w_wrap && r_score != 16'hFFFF && r_score[3:0] == 4'hF && r_step < 4'd8) r_step <= r_step + 4'd1;
    assign w_step = r_step;
`else
    assign w_step = 4'(SCROLL_STEP);
`endif
    // GroundY is refreshed one cycle after the ring moves, from the settled head/offset.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state    <= FILL;
            r_cnt      <= '0;
            r_head     <= '0;
            r_off      <= '0;
            r_score    <= '0;
            r_gy       <= 10'd400;
            r_playing  <= 1'b0;
            r_upd      <= 1'b0;
            r_prev_gap <= 1'b0;
            r_fc       <= '0;
            for (int i = 0; i < 16; i++) r_lvl[i] <= 3'd1;
        end else begin
            r_fc  <= {r_fc[0], frame_clk};
            r_upd <= 1'b0;
            if (r_upd) r_gy <= w_gy_min;
            case (r_state)
                FILL: begin
                    r_lvl[r_cnt] <= 3'd1;
                    r_cnt        <= r_cnt + 4'd1;
                    r_head       <= '0;
                    r_off        <= '0;
                    r_score      <= '0;
                    r_prev_gap   <= 1'b0;
                    if (r_cnt == 4'd15) begin
                        r_state <= IDLE;
                        r_upd   <= 1'b1;
                    end
                end
                IDLE: if (keycode == KEY_ENTER) begin
                    r_state   <= PLAYING;
                    r_playing <= 1'b1;
                end
                PLAYING: if (w_tick && w_dead) begin
                    r_state   <= DEAD;
                    r_playing <= 1'b0;
                end else if (w_adv) begin
                    r_off <= w_sum[SH-1:0];
                    r_upd <= 1'b1;
                    if (w_wrap) begin
                        r_head        <= r_head + 4'd1;
                        r_lvl[r_head] <= w_new;
                        r_prev_gap    <= (w_new == 3'd0);
                        if (r_score != 16'hFFFF) r_score <= r_score + 16'd1;
                    end
                end
                DEAD: if (keycode == KEY_ENTER) begin
                    r_state <= FILL;
                    r_cnt   <= '0;
                end
                default: r_state <= FILL;
            endcase
        end
    end
endmodule

// File: tb/tb_ground_gen.sv
// tb_ground_gen: directed bench for ground_gen with a world-position terrain model and a FIFO scoreboard.
module tb_ground_gen;
    import runner_pkg::*;
    localparam int SEG_W = 64, STEP = 4, SX = 100, SW = 56, FALL = 470;
    logic        Clk = 1'b0, Reset = 1'b1, frame_clk = 1'b0;
    logic [7:0]  keycode = 8'h00;
    logic [9:0]  sb = 10'd400, DrawX = 10'd0, DrawY = 10'd0;
    logic [9:0]  GroundY;
    logic        playing, is_ground;
    logic [15:0] Score;
    int          n_vec = 0, n_fail = 0;
    int          exp_q[$];
    string       tag_q[$];
    // Terrain model: world[k] is the k-th segment since FILL; pos is total pixels scrolled.
    int          world[4096];
    int          pos, m_gy, m_score;
    bit          m_play, m_gap;
    logic [15:0] m_lfsr;

    ground_gen dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .StickmanBottom(sb), .DrawX(DrawX), .DrawY(DrawY),
        .GroundY(GroundY), .playing(playing), .Score(Score), .is_ground(is_ground)
    );

    always #10 Clk = ~Clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic int floor_of(int l);
        return (l == 0) ? 480 : 416 - 16 * l;
    endfunction

    function automatic int lvl_at(int c);
        return world[(c + pos) / SEG_W];
    endfunction

    task automatic m_fill();
        pos = 0; m_score = 0; m_gap = 0; m_gy = 400;
        for (int i = 0; i < 16; i++) world[i] = 1;
    endtask

    task automatic m_tick(int b);
        int st, l, fa, fb;
        if (!m_play) return;
        if (b > m_gy || b >= FALL) begin
            m_play = 0;
            return;
        end
`ifdef GROUND_SPEEDUP_EN
        st = STEP + m_score / 16;
        if (st > 8) st = 8;
`else
        st = STEP;
`endif
        if ((pos % SEG_W) + st >= SEG_W) begin
            l = int'(m_lfsr[2:0]);
            if (l == 0 && m_gap) l = 1;
            m_gap = (l == 0);
            world[pos / SEG_W + 16] = l;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
            m_score++;
        end
        pos += st;
        fa = floor_of(lvl_at(SX));
        fb = floor_of(lvl_at(SX + SW - 1));
        m_gy = (fa < fb) ? fa : fb;
    endtask

    task automatic push(string t, int v);
        tag_q.push_back(t);
        exp_q.push_back(v);
    endtask

    task automatic pop_check(logic [31:0] obs);
        string t;
        int e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard: observed %0d with no expected entry", obs);
            return;
        end
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        assert (obs === 32'(e)) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", t, obs, e);
        end
    endtask

    task automatic expect_status();
        push("GroundY", m_gy);
        push("playing", int'(m_play));
        push("Score", m_score);
    endtask

    task automatic check_status();
        pop_check(32'(GroundY));
        pop_check(32'(playing));
        pop_check(32'(Score));
    endtask

    task automatic probe(int x, int y);
        int l;
        l = lvl_at(x);
        DrawX = 10'(x);
        DrawY = 10'(y);
        push($sformatf("is_ground(%0d,%0d)", x, y), (l != 0 && y >= floor_of(l)) ? 1 : 0);
        #1 pop_check(32'(is_ground));
    endtask

    task automatic probe_col(int x);
        int f;
        f = floor_of(lvl_at(x));
        probe(x, f);
        probe(x, f - 1);
    endtask

    task automatic frame(int b);
        sb = 10'(b);
        m_tick(b);
        expect_status();
        frame_clk = 1'b1;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        check_status();
        probe_col(SX);
        probe_col(SX + SW - 1);
        probe_col(320);
        probe_col(639);
        probe(int'($urandom_range(0, 639)), int'($urandom_range(290, 479)));
    endtask

    function automatic int jump_sb();
        return (m_gy == 480) ? 400 : m_gy;
    endfunction

    initial begin
        int found;
        m_lfsr = 16'hACE1;
        m_play = 0;
        m_fill();
        expect_status();
        @(negedge Clk);
        check_status();
        Reset = 1'b0;
        repeat (17) @(negedge Clk);
        expect_status();
        check_status();
        probe(320, 400);
        probe(320, 399);
        probe(320, 479);
        frame(400);
        keycode = KEY_ENTER;
        m_play = 1;
        push("playing_after_enter", 1);
        @(negedge Clk);
        keycode = 8'h00;
        pop_check(32'(playing));
        for (int i = 0; i < 16; i++) frame(400);
        for (int i = 0; i < 1100; i++) frame(jump_sb());
        found = 0;
        for (int i = 0; i < 500 && found == 0; i++)
            if (m_gy == 480) begin
                frame(470);
                found = 1;
            end else frame(jump_sb());
        if (found == 0) begin
            n_fail++;
            $error("FAIL gap_search: no full gap reached the stickman within the frame budget");
        end
        frame(470);
        frame(400);
        keycode = KEY_ENTER;
        @(negedge Clk);
        keycode = 8'h00;
        m_fill();
        m_play = 0;
        repeat (17) @(negedge Clk);
        expect_status();
        check_status();
        probe(320, 400);
        probe(320, 399);
        keycode = KEY_ENTER;
        m_play = 1;
        push("playing_after_enter", 1);
        @(negedge Clk);
        keycode = 8'h00;
        pop_check(32'(playing));
        for (int i = 0; i < 800 && m_play; i++) frame(400);
        if (m_play) begin
            n_fail++;
            $error("FAIL wall_search: no wall death within the frame budget");
        end
        frame(400);
        frame(400);
        keycode = KEY_ENTER;
        m_fill();
        m_play = 0;
        push("playing_enter_held_fill", 0);
        repeat (17) @(negedge Clk);
        pop_check(32'(playing));
        push("playing_enter_held_idle", 1);
        @(negedge Clk);
        pop_check(32'(playing));
        keycode = 8'h00;
        m_play = 1;
        for (int i = 0; i < 20; i++) frame(jump_sb());
        Reset = 1'b1;
        m_lfsr = 16'hACE1;
        m_fill();
        m_play = 0;
        expect_status();
        #1 check_status();
        keycode = KEY_ENTER;
        @(negedge Clk);
        Reset = 1'b0;
        push("playing_after_reset_fill", 0);
        repeat (16) @(negedge Clk);
        pop_check(32'(playing));
        push("playing_after_reset_idle", 1);
        @(negedge Clk);
        pop_check(32'(playing));
        keycode = 8'h00;
        m_play = 1;
        for (int i = 0; i < 260; i++) frame(jump_sb());
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule

// File: doc/ground_gen.md
# ground_gen

Scrolling-terrain generator and game-state controller for the runner. Holds a 16-slot ring of floor segments, scrolls them left once per frame, and generates new segments from an LFSR. It drives the `GroundY` floor height and the `playing` status consumed by the stickman block, and takes back `StickmanBottom` for collision and fall detection. It also reports per-pixel `is_ground` to the colour mapper.

## Interface
- `SEG_W`, 64: segment width in pixels; power of two.
- `SCROLL_STEP`, 4: pixels scrolled per frame.
- `STICK_X`, 100: stickman left column.
- `STICK_W`, 56: stickman width; must be less than `SEG_W`.
- `FALL_Y`, 470: a bottom row at or below this value counts as fallen.
- `LFSR_SEED`, 16'hACE1: LFSR value at reset.
- `Clk`  in  1  system clock, 50 MHz.
- `Reset`  in  1  asynchronous, active-high.
- `frame_clk`  in  1  frame strobe, ~60 Hz, asynchronous level.
- `keycode`  in  8  last received key.
- `StickmanBottom`  in  10  stickman bottom row.
- `DrawX`, `DrawY`  in  10  current pixel.
- `GroundY`  out  10  floor row under the stickman, registered.
- `playing`  out  1  high while in PLAYING.
- `Score`  out  16  segments passed, saturating.
- `is_ground`  out  1  current pixel is floor; combinational.

## Operation
- Frame tick: a rising edge of `frame_clk`, detected by a two-flop delay on `Clk`.
- Segment level is 3 bits.
  - Level 0 is a gap, with floor 480.
  - Level L = 1..7 has floor `416 - 16*L`: L=1 gives 400, L=7 gives 304.
- Ring state:
  - `lvl[0:15]`.
  - `head` (4-bit), the slot at screen X=0.
  - `offset` (6-bit), range 0..SEG_W-1.
- Pixel-to-slot mapping: `rel = (X + offset) >> log2(SEG_W)`; `slot = (head + rel) mod 16`. Use 11-bit sums.
- `is_ground` = `lvl[slot(DrawX)] != 0` and `DrawY >= floor(slot(DrawX))`.
- States:
  - FILL: writes `lvl[i]=1` for i = 0..15, one slot per Clk. Clears `offset`, `head`, `Score`. After 16 cycles goes to IDLE.
  - IDLE: terrain frozen. `keycode==8'h28` (Enter) goes to PLAYING.
  - PLAYING: scrolls on each frame tick; death goes to DEAD.
  - DEAD: terrain frozen, `Score` held. Enter goes to FILL.
- Scroll, PLAYING only, on a frame tick:
  - `sum = offset + step`.
  - If `sum >= SEG_W`: `offset = sum - SEG_W`, `head++`, the old head slot is rewritten with a new level, the LFSR advances one step, and `Score` increments (saturating at 16'hFFFF).
  - Otherwise `offset = sum`.
- New level:
  - Level = `lfsr[2:0]`.
  - If that is 0 and the previous new level was 0, force level 1. No two consecutive gaps.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances only on segment generation. It is not reseeded by FILL, only by `Reset`.
- `GroundY` = min(floor at column `STICK_X`, floor at column `STICK_X+STICK_W-1`). Recomputed the cycle after each scroll and at the end of FILL.
- Death check, PLAYING only, on a frame tick, evaluated before the scroll:
  - Dead if `StickmanBottom > GroundY` (wall hit) or `StickmanBottom >= FALL_Y` (fell).
  - On death, no scroll occurs on that tick.

## Timing
- Reset values:
  - State = FILL.
  - `GroundY`=400, `playing`=0, `Score`=0.
  - `offset`=0, `head`=0, LFSR=`LFSR_SEED`.
  - `is_ground` follows its inputs, combinationally.
- A frame tick is acted on 2 Clk cycles after the `frame_clk` rise. `GroundY` updates one Clk after that.
- `playing` is registered; it rises the Clk after Enter is sampled in IDLE.
- Enter held through FILL starts play on the first IDLE cycle.
- `Reset` mid-play returns to FILL immediately.
- A frame tick during FILL, IDLE or DEAD is ignored.
- Death and segment wrap on the same tick: death wins, with no wrap and no score increment.

## Configuration
- `GROUND_SPEEDUP_EN`, defined: step starts at `SCROLL_STEP` and increases by 1 every 16 `Score` increments, capped at 8. Step resets to `SCROLL_STEP` in FILL.
- `GROUND_SPEEDUP_EN`, undefined: step is constant `SCROLL_STEP`.

## Structure
- Package `runner_pkg`:
  - `game_state_t` enum (FILL, IDLE, PLAYING, DEAD).
  - Level-to-floor function.
  - Key codes `KEY_SPACE`=8'h2c, `KEY_ENTER`=8'h28.
  - Screen constants 640/480.
- Sub-module `lfsr16`: ports `Clk`, `Reset`, `step`, `value[15:0]`.

## Test plan
- Reset, wait 16 Clk -> state IDLE, `GroundY`=400, `is_ground`=1 at (320,400), `is_ground`=0 at (320,399).
- Enter, then 16 frame ticks with `StickmanBottom`=400 and a flat ring -> `head`=1, `offset`=0, `Score`=1, one LFSR step taken.
- Preload slots 1 and 2 with level 0, `StickmanBottom`=400, scroll until `GroundY`=480 -> first new level after a gap is never 0. On reaching `StickmanBottom`=470, the next tick gives DEAD and `playing`=0.
- Slot under column 155 has level 3 (floor 368) while `StickmanBottom`=400 -> DEAD on the next tick, `Score` frozen.
- DEAD, Enter -> FILL for 16 Clk, then IDLE, `Score`=0, LFSR not reseeded.
- With `GROUND_SPEEDUP_EN`: after `Score`=16 the step is 5; it saturates at 8 when `Score`=64.
